writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the register file.
- Collects results from NSRC functional units, each through a valid/ready handshake, and buffers each source in a small FIFO.
- Round-robin arbitrates the buffered results onto the register file's single write port (we/wa/wd), one write per cycle.
- Exports a pending-write mask to issue logic for hazard checks.

Parameters:
- NSRC, 3, number of result sources (functional units)
- DW, 32, data width
- AW, 5, register address width (32 registers)
- DEPTH, 2, per-source FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock; all state on posedge
- reset  input  1  asynchronous, active-low reset
- src_valid  input  NSRC  per-source result valid
- src_ready  output  NSRC  per-source FIFO not full
- src_addr  input  NSRC*AW  destination register, source i at bits [i*AW +: AW]
- src_data  input  NSRC*DW  result data, source i at bits [i*DW +: DW]
- we  output  1  register file write enable
- wa  output  AW  register file write address
- wd  output  DW  register file write data
- pending_mask  output  2**AW  bit r set while a write to r is buffered or on the write port
- stat_writes  output  32  count of writes issued (see Optional Feature)
- stat_stalls  output  32  count of stall cycles (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - all FIFOs empty; we=0, wa=0, wd=0
  - round-robin pointer=0
  - src_ready is all-ones once reset deasserts
  - pending_mask=0; stat counters=0
- Accept: source i pushes on a posedge where src_valid[i] & src_ready[i]. src_ready[i] = (count_i != DEPTH), taken from registered count only. A full FIFO that is popping in the same cycle still shows ready=0, so there is no combinational ready path.
- Arbitration, each cycle:
  - candidates are the non-empty FIFO heads
  - grant the first candidate searching from (last_grant+1) mod NSRC upward, wrapping
  - pop the granted head; last_grant <= granted index
  - last_grant is unchanged when there are no candidates
- Output register:
  - on grant, next cycle we=1, wa=head.addr, wd=head.data; otherwise we=0, with wa/wd holding their last values
  - latency: push at edge N into an empty FIFO with no competition -> we=1 during the cycle after edge N+1 (2 edges)
- r0 writes: accepted and granted like any entry, but the output register loads we=0. They consume an arbitration slot and never reach the register file.
- Ordering:
  - FIFO order is preserved per source
  - across sources, grant order decides; a later grant to the same register wins
  - issue logic prevents same-register races using pending_mask
- pending_mask: combinational OR of one-hot(addr) over all valid FIFO entries plus (we ? one-hot(wa) : 0). Bit 0 is forced to 0.
- Simultaneous push and pop on the same FIFO: both take effect; count is unchanged.
- Sustained throughput is 1 write/cycle total. With all sources saturated, each source receives 1 grant per NSRC cycles.
- Reset mid-operation drops all buffered writes immediately; we falls asynchronously.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - stat_writes increments on every cycle with we=1
  - stat_stalls increments on every cycle where any src_valid[i] & !src_ready[i]
  - both are 32-bit, wrap at 2^32, and clear on reset
- Undefined: the counters are not built; stat_writes and stat_stalls are tied to 0. Ports exist in both builds.

Decomposition:
- Package wb_pkg:
  - constants DW, AW, NREG=2**AW
  - typedef wb_req_t packed {addr[AW], data[DW]}
  - function onehot_reg(addr)
- Sub-module wb_fifo:
  - parameterised DEPTH, payload wb_req_t
  - ports: push/pop, full/empty, head, entry-valid vector plus entries (for pending_mask)
  - instantiated NSRC times

Test Plan:
- Reset release, src0 pushes (addr=3, data=0xDEADBEEF) at edge 1 -> we=1, wa=3, wd=0xDEADBEEF in the cycle after edge 2; pending_mask[3]=1 from edge 1 through the write cycle, then 0.
- All 3 sources push in the same cycle (addr 1/2/4) -> writes appear on consecutive cycles in order 0,1,2. A following simultaneous burst grants 0,1,2 again, rotating from last_grant.
- Source 1 pushes 3 back-to-back entries while sources 0 and 2 saturate -> src_ready[1]=0 after 2 entries. With WB_ARB_STATS_EN, stat_stalls increments once per stalled cycle. No entry is lost or reordered within source 1.
- Push to addr 0 with data 0x1234 -> a grant slot is consumed, we stays 0 that cycle, and pending_mask[0] is never set.
- Assert reset low mid-burst with 4 entries buffered -> we, pending_mask and src_ready clear asynchronously. After release, no stale writes appear.
- Two sources write addr 7 (data 0xA, then 0xB) in the same cycle with last_grant=0 -> source 1 is granted first, so register 7 ends with source 2's data. pending_mask[7] holds until the second write completes.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter: request payload and
// a one-hot register decode used to build the pending-write mask.
package wb_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 2**AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    function automatic logic [NREG-1:0] onehot_reg(input logic [AW-1:0] addr);
        logic [NREG-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result-source handshake, register-file write port and hazard mask of the
// writeback arbiter. master = functional units / issue side, slave = arbiter.
interface writeback_arbiter_if #(
    parameter int NSRC = 3
);
    import wb_pkg::*;

    logic [NSRC-1:0]    src_valid;
    logic [NSRC-1:0]    src_ready;
    logic [NSRC*AW-1:0] src_addr;
    logic [NSRC*DW-1:0] src_data;
    logic               we;
    logic [AW-1:0]      wa;
    logic [DW-1:0]      wd;
    logic [NREG-1:0]    pending_mask;

    modport master (
        output src_valid, src_addr, src_data,
        input  src_ready, we, wa, wd, pending_mask
    );

    modport slave (
        input  src_valid, src_addr, src_data,
        output src_ready, we, wa, wd, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-source result FIFO; exposes every slot and its valid bit so the
// arbiter can see all buffered destinations at once.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  wb_req_t          push_data,
    output logic             full,
    output logic             empty,
    output wb_req_t          head,
    output logic [DEPTH-1:0] entry_valid,
    output wb_req_t          entries [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t       mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Payload storage carries no reset; slot validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_data;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot
        logic [PW-1:0] rel;
        assign rel             = PW'(gi) - rd_ptr_reg;
        assign entry_valid[gi] = ({1'b0, rel} < count_reg);
        assign entries[gi]     = mem_reg[gi];
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: buffers NSRC result streams and drives the
// single register-file write port. Statistics counters need WB_ARB_STATS_EN.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int NSRC  = 3,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    writeback_arbiter_if.slave  bus,
    output logic [31:0]         stat_writes,
    output logic [31:0]         stat_stalls
);

    localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]            push;
    logic [NSRC-1:0]            pop;
    logic [NSRC-1:0]            full;
    logic [NSRC-1:0]            empty;
    logic [NSRC-1:0]            src_ready;
    wb_req_t                    push_req [NSRC];
    wb_req_t                    head_arr [NSRC];
    logic [NSRC-1:0][NREG-1:0]  fifo_mask;

    logic [GW-1:0]   last_grant_reg;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;
    logic            grant_valid;
    wb_req_t         grant_req;
    logic            we_reg;
    logic [AW-1:0]   wa_reg;
    logic [DW-1:0]   wd_reg;
    logic [NREG-1:0] pend;

    // Ready depends only on registered occupancy and is held low during reset.
    assign src_ready     = ~full & {NSRC{reset}};
    assign bus.src_ready = src_ready;
    assign push          = bus.src_valid & src_ready;

    for (genvar gi = 0; gi < NSRC; gi++) begin : gen_src
        logic [DEPTH-1:0] ent_valid;
        wb_req_t          ents [DEPTH];
        logic [NREG-1:0]  mask;

        assign push_req[gi] = {bus.src_addr[gi*AW +: AW], bus.src_data[gi*DW +: DW]};

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (push[gi]),
            .pop         (pop[gi]),
            .push_data   (push_req[gi]),
            .full        (full[gi]),
            .empty       (empty[gi]),
            .head        (head_arr[gi]),
            .entry_valid (ent_valid),
            .entries     (ents)
        );

        always_comb begin
            mask = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (ent_valid[k]) mask |= onehot_reg(ents[k].addr);
            end
        end

        assign fifo_mask[gi] = mask;
    end

    // Search starts one past the previous winner and wraps.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant_reg;
        cand        = '0;
        for (int k = 1; k <= NSRC; k++) begin
            cand = GW'((int'(last_grant_reg) + k) % NSRC);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_req = head_arr[grant_idx];
    assign pop       = grant_valid ? (NSRC'(1) << grant_idx) : '0;

    // r0 writes use up their grant but never assert the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_reg         <= 1'b0;
            wa_reg         <= '0;
            wd_reg         <= '0;
            last_grant_reg <= '0;
        end else begin
            we_reg <= grant_valid && (grant_req.addr != '0);
            if (grant_valid) begin
                last_grant_reg <= grant_idx;
                if (grant_req.addr != '0) begin
                    wa_reg <= grant_req.addr;
                    wd_reg <= grant_req.data;
                end
            end
        end
    end

    assign bus.we = we_reg;
    assign bus.wa = wa_reg;
    assign bus.wd = wd_reg;

    always_comb begin
        pend = we_reg ? onehot_reg(wa_reg) : '0;
        for (int i = 0; i < NSRC; i++) pend |= fifo_mask[i];
        pend[0] = 1'b0;
    end

    assign bus.pending_mask = pend;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_writes_reg;
    logic [31:0] stat_stalls_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_writes_reg <= '0;
            stat_stalls_reg <= '0;
        end else begin
            if (we_reg) stat_writes_reg <= stat_writes_reg + 32'd1;
            if (|(bus.src_valid & ~src_ready)) stat_stalls_reg <= stat_stalls_reg + 32'd1;
        end
    end

    assign stat_writes = stat_writes_reg;
    assign stat_stalls = stat_stalls_reg;
`else
    assign stat_writes = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: latency, rotation, back-pressure,
// r0 slots, asynchronous reset and same-register ordering.
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] stat_writes;
    logic [31:0] stat_stalls;
    int          checks;
    int          errors;

`ifdef WB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic [4:0]  t3_wa [5] = '{5'd10, 5'd11, 5'd12, 5'd10, 5'd11};
    logic [31:0] t3_wd [5] = '{32'hA0A0, 32'h102, 32'hC2C2, 32'hA0A0, 32'h103};

    writeback_arbiter_if #(.NSRC(3)) bus ();

    writeback_arbiter #(.NSRC(3), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .stat_writes (stat_writes),
        .stat_stalls (stat_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
        bus.src_valid[i]            = v;
        bus.src_addr[i*AW +: AW]    = a;
        bus.src_data[i*DW +: DW]    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.we) $display("write wa=%0d wd=%h", bus.wa, bus.wd);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.src_valid = '0;
        bus.src_addr  = '0;
        bus.src_data  = '0;

        // Reset state
        #2;
        check("rst_we", bus.we, 1'b0);
        check("rst_wa", bus.wa, 5'd0);
        check("rst_wd", bus.wd, 32'd0);
        check("rst_pend", bus.pending_mask, 32'd0);
        check("rst_ready_low", bus.src_ready, 3'b000);
        check("rst_stat_w", stat_writes, 32'd0);
        #10;
        reset = 1'b1;
        #1;
        check("rel_ready", bus.src_ready, 3'b111);

        // Single push latency
        set_src(0, 1, 5'd3, 32'hDEADBEEF);
        tick();
        set_src(0, 0, 5'd0, 32'd0);
        check("t1_pend_buf", bus.pending_mask, 32'h8);
        check("t1_we_early", bus.we, 1'b0);
        tick();
        check("t1_we", bus.we, 1'b1);
        check("t1_wa", bus.wa, 5'd3);
        check("t1_wd", bus.wd, 32'hDEADBEEF);
        check("t1_pend_wr", bus.pending_mask, 32'h8);
        tick();
        check("t1_we_off", bus.we, 1'b0);
        check("t1_pend_clr", bus.pending_mask, 32'h0);
        check("t1_wa_hold", bus.wa, 5'd3);

        // Move last grant to source 2
        set_src(2, 1, 5'd9, 32'h99);
        tick();
        set_src(2, 0, 5'd0, 32'd0);
        tick();
        check("t2_pre_wa", bus.wa, 5'd9);
        tick();

        // Two simultaneous bursts, each granted 0,1,2
        for (int b = 0; b < 2; b++) begin
            set_src(0, 1, (b == 0) ? 5'd1 : 5'd5, 32'h11 + b);
            set_src(1, 1, (b == 0) ? 5'd2 : 5'd6, 32'h22 + b);
            set_src(2, 1, (b == 0) ? 5'd4 : 5'd8, 32'h44 + b);
            tick();
            for (int i = 0; i < 3; i++) set_src(i, 0, 5'd0, 32'd0);
            check("t2_pend", bus.pending_mask, (b == 0) ? 32'h16 : 32'h160);
            tick();
            check("t2_wa_s0", bus.wa, (b == 0) ? 5'd1 : 5'd5);
            check("t2_wd_s0", bus.wd, 32'h11 + b);
            tick();
            check("t2_wa_s1", bus.wa, (b == 0) ? 5'd2 : 5'd6);
            tick();
            check("t2_wa_s2", bus.wa, (b == 0) ? 5'd4 : 5'd8);
            check("t2_we_s2", bus.we, 1'b1);
            tick();
            check("t2_idle", bus.we, 1'b0);
        end

        // Back-pressure on source 1 while 0 and 2 saturate
        set_src(0, 1, 5'd10, 32'hA0A0);
        set_src(1, 1, 5'd11, 32'h101);
        set_src(2, 1, 5'd12, 32'hC2C2);
        tick();
        set_src(1, 1, 5'd11, 32'h102);
        tick();
        check("t3_ready_e2", bus.src_ready, 3'b001);
        check("t3_wa_e2", bus.wa, 5'd10);
        set_src(1, 1, 5'd11, 32'h103);
        tick();
        check("t3_ready_e3", bus.src_ready, 3'b010);
        check("t3_wd_e3", bus.wd, 32'h101);
        tick();
        check("t3_ready_e4", bus.src_ready, 3'b100);
        check("t3_wa_e4", bus.wa, 5'd12);
        for (int i = 0; i < 3; i++) set_src(i, 0, 5'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_we_seq", bus.we, 1'b1);
            check("t3_wa_seq", bus.wa, t3_wa[k]);
            check("t3_wd_seq", bus.wd, t3_wd[k]);
        end
        tick();
        check("t3_drain", bus.we, 1'b0);
        check("t3_stalls", stat_stalls, STATS ? 32'd2 : 32'd0);
        check("t3_writes", stat_writes, STATS ? 32'd16 : 32'd0);

        // r0 consumes a grant slot ahead of source 1
        set_src(0, 1, 5'd0, 32'h1234);
        set_src(1, 1, 5'd13, 32'h1313);
        tick();
        set_src(0, 0, 5'd0, 32'd0);
        set_src(1, 0, 5'd0, 32'd0);
        check("t4_pend", bus.pending_mask, 32'h2000);
        tick();
        check("t4_r0_we", bus.we, 1'b0);
        check("t4_r0_wd_hold", bus.wd, 32'h103);
        tick();
        check("t4_we", bus.we, 1'b1);
        check("t4_wa", bus.wa, 5'd13);
        tick();
        check("t4_pend_clr", bus.pending_mask, 32'h0);
        check("t4_writes", stat_writes, STATS ? 32'd17 : 32'd0);

        // Asynchronous reset with four entries buffered
        set_src(0, 1, 5'd14, 32'h14);
        set_src(1, 1, 5'd15, 32'h15);
        set_src(2, 1, 5'd16, 32'h16);
        tick();
        set_src(0, 1, 5'd17, 32'h17);
        set_src(1, 1, 5'd18, 32'h18);
        set_src(2, 0, 5'd0, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) set_src(i, 0, 5'd0, 32'd0);
        check("t5_pend_full", bus.pending_mask, 32'h7C000);
        check("t5_we_pre", bus.we, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_we_async", bus.we, 1'b0);
        check("t5_pend_async", bus.pending_mask, 32'h0);
        check("t5_ready_async", bus.src_ready, 3'b000);
        check("t5_stat_clr", stat_writes, 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check("t5_ready_rel", bus.src_ready, 3'b111);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_stale_we", bus.we, 1'b0);
            check("t5_no_stale_pend", bus.pending_mask, 32'h0);
        end

        // Same register from two sources, last grant 0 after reset
        set_src(1, 1, 5'd7, 32'hA);
        set_src(2, 1, 5'd7, 32'hB);
        tick();
        set_src(1, 0, 5'd0, 32'd0);
        set_src(2, 0, 5'd0, 32'd0);
        check("t6_pend", bus.pending_mask, 32'h80);
        tick();
        check("t6_first_wd", bus.wd, 32'hA);
        check("t6_pend_mid", bus.pending_mask, 32'h80);
        tick();
        check("t6_second_wd", bus.wd, 32'hB);
        check("t6_pend_last", bus.pending_mask, 32'h80);
        tick();
        check("t6_we_off", bus.we, 1'b0);
        check("t6_pend_clr", bus.pending_mask, 32'h0);
        check("t6_final_wd", bus.wd, 32'hB);
        check("t6_writes", stat_writes, STATS ? 32'd2 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
